// File: rtl/gb_lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gb_lcd_pkg
// Summary  : Game Boy LCD geometry, framebuffer widths and capture FSM states,
//            shared with the VGA scan-out block.
// Revision : 1.0
// ============================================================================
package gb_lcd_pkg;

  localparam int GB_W  = 160;
  localparam int GB_H  = 144;
  localparam int FB_AW = 15;
  localparam int FB_DW = 2;

  localparam logic [0:0] WAIT_FRAME = 1'b0;
  localparam logic [0:0] ACTIVE     = 1'b1;

  typedef logic [FB_AW-1:0] fb_addr_t;
  typedef logic [FB_DW-1:0] fb_data_t;

endpackage
`default_nettype wire

// File: rtl/gb_lcd_capture_sync.sv
`default_nettype none
// ============================================================================
// Module   : lcd_sync_edge
// Summary  : Multi-flop synchronizer with one alignment flop and optional
//            registered rise/fall detection on bit 0.
// Revision : 1.0
// ============================================================================
module lcd_sync_edge #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_DET    = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] level_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] hold_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hold_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hold_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // The level output is delayed one flop so it lines up with the edge flags.
  assign level_o = hold_q;

  generate
    if (EDGE_DET) begin : g_edge
      logic rise_q;
      logic fall_q;

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          rise_q <=  sync_q[SYNC_STAGES-1][0] & ~hold_q[0];
          fall_q <= ~sync_q[SYNC_STAGES-1][0] &  hold_q[0];
        end
      end

      assign rise_o = rise_q;
      assign fall_o = fall_q;
    end else begin : g_level_only
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/gb_lcd_capture.sv
`default_nettype none
// ============================================================================
// Module   : gb_lcd_capture
// Summary  : Captures the Game Boy LCD pixel stream into a row-major 2-bit
//            framebuffer and reports frame completion and timing errors.
// Revision : 1.0
// ============================================================================
module gb_lcd_capture
  import gb_lcd_pkg::*;
#(
  parameter int H_PIXELS    = GB_W,
  parameter int V_LINES     = GB_H,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             lcd_clk_i,
  input  logic             lcd_hsync_i,
  input  logic             lcd_vsync_i,
  input  logic [FB_DW-1:0] lcd_data_i,
  input  logic             capture_en_i,
  output logic [FB_AW-1:0] fb_wr_addr_o,
  output logic [FB_DW-1:0] fb_wr_data_o,
  output logic             fb_we_o,
  output logic             frame_done_o,
  output logic             frame_err_o
);

  localparam logic [7:0]       X_END     = 8'(H_PIXELS);
  localparam logic [7:0]       Y_END     = 8'(V_LINES);
  localparam logic [FB_AW-1:0] LINE_STEP = FB_AW'(H_PIXELS);

  logic       pix_edge, line_edge, frame_edge;
  logic       pclk_lvl, pclk_rise, hs_lvl, hs_fall, vs_lvl, vs_fall, dat_rise, dat_fall;
  fb_data_t   data_sync;
  logic       unused_sigs;

  lcd_sync_edge #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_pclk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (lcd_clk_i),
    .level_o (pclk_lvl),
    .rise_o  (pclk_rise),
    .fall_o  (pix_edge)
  );

  lcd_sync_edge #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_hsync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (lcd_hsync_i),
    .level_o (hs_lvl),
    .rise_o  (line_edge),
    .fall_o  (hs_fall)
  );

  lcd_sync_edge #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_vsync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (lcd_vsync_i),
    .level_o (vs_lvl),
    .rise_o  (frame_edge),
    .fall_o  (vs_fall)
  );

  lcd_sync_edge #(.WIDTH(FB_DW), .SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_data (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (lcd_data_i),
    .level_o (data_sync),
    .rise_o  (dat_rise),
    .fall_o  (dat_fall)
  );

  assign unused_sigs = &{1'b0, pclk_lvl, pclk_rise, hs_lvl, hs_fall, vs_lvl, vs_fall,
                         dat_rise, dat_fall};

  logic [0:0]       state_q, state_d;
  logic [7:0]       x_q, x_d, y_q, y_d;
  logic [FB_AW-1:0] line_base_q, line_base_d;
  logic             line_long_q, line_long_d;
  logic             frame_bad_q, frame_bad_d;
  logic [FB_AW-1:0] fb_wr_addr_q, fb_wr_addr_d;
  fb_data_t         fb_wr_data_q, fb_wr_data_d;
  logic             fb_we_q, fb_we_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;

  logic [7:0]       x_cur;
  logic             long_cur;
  logic             bad_cur;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    line_base_d  = line_base_q;
    line_long_d  = line_long_q;
    frame_bad_d  = frame_bad_q;
    fb_wr_addr_d = fb_wr_addr_q;
    fb_wr_data_d = fb_wr_data_q;
    fb_we_d      = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    x_cur        = x_q;
    long_cur     = line_long_q;
    bad_cur      = frame_bad_q;

    case (state_q)
      WAIT_FRAME: begin
        if (frame_edge && capture_en_i) begin
          state_d     = ACTIVE;
          x_d         = '0;
          y_d         = '0;
          line_base_d = '0;
          line_long_d = 1'b0;
          frame_bad_d = 1'b0;
        end
      end

      default: begin
        if (frame_edge) begin
          // Early vsync aborts the frame; any coincident pixel is dropped.
          frame_err_d = 1'b1;
          x_d         = '0;
          y_d         = '0;
          line_base_d = '0;
          line_long_d = 1'b0;
          frame_bad_d = 1'b0;
          state_d     = capture_en_i ? ACTIVE : WAIT_FRAME;
        end else begin
          if (pix_edge) begin
            if (x_q < X_END) begin
              fb_wr_addr_d = line_base_q + {{(FB_AW-8){1'b0}}, x_q};
              fb_wr_data_d = data_sync;
              fb_we_d      = 1'b1;
              x_cur        = x_q + 8'd1;
            end else begin
              long_cur = 1'b1;
            end
          end
          x_d         = x_cur;
          line_long_d = long_cur;

          // Line end sees the pixel count after any same-cycle write.
          if (line_edge) begin
            if ((x_cur != X_END) || long_cur) begin
              frame_err_d = 1'b1;
              bad_cur     = 1'b1;
            end
            frame_bad_d = bad_cur;
            x_d         = '0;
            line_long_d = 1'b0;
            y_d         = y_q + 8'd1;
            line_base_d = line_base_q + LINE_STEP;
            if ((y_q + 8'd1) == Y_END) begin
              frame_done_d = 1'b1;
              state_d      = WAIT_FRAME;
              if (!bad_cur) frame_err_d = 1'b0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= WAIT_FRAME;
      x_q          <= '0;
      y_q          <= '0;
      line_base_q  <= '0;
      line_long_q  <= 1'b0;
      frame_bad_q  <= 1'b0;
      fb_wr_addr_q <= '0;
      fb_wr_data_q <= '0;
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_base_q  <= line_base_d;
      line_long_q  <= line_long_d;
      frame_bad_q  <= frame_bad_d;
      fb_wr_addr_q <= fb_wr_addr_d;
      fb_wr_data_q <= fb_wr_data_d;
      fb_we_q      <= fb_we_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign fb_wr_addr_o = fb_wr_addr_q;
  assign fb_wr_data_o = fb_wr_data_q;
  assign fb_we_o      = fb_we_q;
  assign frame_done_o = frame_done_q;
  assign frame_err_o  = frame_err_q;

endmodule
`default_nettype wire

// File: doc/gb_lcd_capture.md
Name: gb_lcd_capture

Overview:
- Upstream neighbour of the VGA scan-out block.
- Samples the Game Boy LCD interface (pixel clock, line latch, frame sync, 2 data bits) asynchronously to `clk`, and writes each 2-bit pixel into the 160x144 dual-port framebuffer.
- Its write port produces the row-major layout (address = y*160 + x) that VGA reads through fb_addr/fb_q.
- Also flags frame completion and frame-timing errors to the AI/control logic.

Parameters:
- H_PIXELS, 160, active pixels per LCD line
- V_LINES, 144, active lines per LCD frame
- SYNC_STAGES, 2, flip-flops in each input synchronizer (min 2)

Ports:
- clk  in  1  system clock (25 MHz, >= 4x LCD pixel clock)
- reset  in  1  synchronous, active-high reset
- lcd_clk  in  1  GB LCD pixel clock, async; data valid on falling edge
- lcd_hsync  in  1  GB line latch, async; rising edge ends a line
- lcd_vsync  in  1  GB frame sync, async; rising edge starts a frame
- lcd_data  in  2  GB pixel data {d1,d0}, async
- capture_en  in  1  allow capture of next frame; sampled at vsync rising edge
- fb_wr_addr  out  15  framebuffer write address
- fb_wr_data  out  2  framebuffer write data
- fb_we  out  1  write strobe, one clk cycle per pixel
- frame_done  out  1  one-cycle pulse after line V_LINES-1 completes
- frame_err  out  1  sticky; set on short/long line or early vsync; cleared by reset or the next clean frame_done

Behaviour:
- Synchronization
  - All four LCD inputs pass through SYNC_STAGES flops, then one edge-detect flop, so data stays aligned with lcd_clk.
  - pix_edge = falling edge of synced lcd_clk.
  - line_edge = rising edge of synced lcd_hsync.
  - frame_edge = rising edge of synced lcd_vsync.
- Reset
  - state=WAIT_FRAME; x=0, y=0, line_base=0.
  - fb_wr_addr=0, fb_wr_data=0, fb_we=0, frame_done=0, frame_err=0.
  - Synchronizer flops clear to 0.
- FSM states: WAIT_FRAME, ACTIVE.
- WAIT_FRAME
  - fb_we held 0; pixel and line edges are ignored.
  - On frame_edge with capture_en=1: x=0, y=0, line_base=0, go to ACTIVE.
  - On frame_edge with capture_en=0: stay in WAIT_FRAME.
- ACTIVE, pix_edge
  - If x<H_PIXELS: fb_wr_addr=line_base+x, fb_wr_data=synced lcd_data, fb_we=1 for exactly one cycle, x++.
  - If x==H_PIXELS: pixel dropped, line_long flag set.
- ACTIVE, line_edge
  - If x!=H_PIXELS, set frame_err.
  - Then x=0, y++, line_base += H_PIXELS (adder only, no multiplier).
  - If the new y==V_LINES: pulse frame_done (only when no error occurred this frame; otherwise pulse anyway and leave frame_err set), go to WAIT_FRAME.
- ACTIVE, frame_edge (early vsync)
  - Set frame_err, restart at x=0, y=0, line_base=0, stay in ACTIVE if capture_en=1, else go to WAIT_FRAME.
  - No frame_done for the aborted frame.
- Simultaneous events, same clk cycle
  - pix_edge + line_edge: pixel written at the current address first, then the line advances (x check uses x after the increment).
  - frame_edge + anything: frame_edge wins; the pixel is dropped.
- Latency: fb_we asserts SYNC_STAGES+2 clk cycles after the lcd_clk falling edge at the pin.
- Widths
  - x is 8 bits, y is 8 bits, line_base is 15 bits; max address 23039 fits in 15 bits.
  - fb_wr_addr never exceeds H_PIXELS*V_LINES-1.
- frame_err is cleared on a frame_done whose frame had no error.

Decomposition:
- Package gb_lcd_pkg: GB_W=160, GB_H=144, FB_AW=15, FB_DW=2, state encoding (WAIT_FRAME=0, ACTIVE=1). These are shared with the VGA block's HBEGIN/VEND geometry.
- Sub-module lcd_sync_edge: SYNC_STAGES synchronizer plus rise/fall detect, one instance per control input. The data bus uses the same synchronizer without the edge detect.

Test Plan:
- Reset held 3 cycles mid-frame, then released -> all outputs 0, state WAIT_FRAME, the next 10 lcd_clk edges produce no fb_we.
- One full frame (vsync, then 144 lines of 160 pixels, data = (x+y)%4, lcd_clk period 6 clk) ->
  - 23040 fb_we pulses;
  - first write addr 0 data 0; addr 161 data 2; last write addr 23039 data (159+143)%4=2;
  - one frame_done; frame_err=0.
- Line 5 given 161 pixels, line 6 given 159 ->
  - the 161st pixel is not written;
  - line 6 addresses still start at 960;
  - frame_err=1 at frame end, and frame_done still pulses.
- vsync raised after line 70 -> frame_err=1, next write addr 0, no frame_done until a full 144 lines follow.
- capture_en=0 at vsync -> zero fb_we for the frame; set capture_en=1 for the following vsync -> normal capture resumes at addr 0.
- pix_edge and line_edge in the same clk cycle on pixel 159 -> write at line_base+159, then x=0, frame_err stays 0.
